// File: rtl/psram_arbiter.sv
// Two-port arbiter/sequencer in front of PsramController: A (slot/mapper) has priority,
// B (background loader/tester) is forced through after B_MAX_DEFER consecutive A grants.
module psram_arbiter #(
  parameter int B_MAX_DEFER = 8,
  parameter int ADDR_W      = 22
) (
  input  logic              clk_72m,
  input  logic              bus_reset_n,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_din,
  output logic              a_ack,
  output logic [7:0]        a_dout,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_din,
  output logic              b_ack,
  output logic [7:0]        b_dout,

  output logic              psram_read,
  output logic              psram_write,
  output logic [ADDR_W-1:0] psram_addr,
  output logic [15:0]       psram_din,
  input  logic [15:0]       psram_dout,
  input  logic              psram_busy,

  output logic              grant_b
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;

  localparam logic [7:0] DEFER_MAX = 8'(B_MAX_DEFER);

  logic [2:0]        state;
  logic [7:0]        defer_cnt;
  logic              cur_we;

  logic              grant_vld;
  logic              pick_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_din;
  logic [7:0]        rd_byte;

  // Arbitration is only meaningful in IDLE; the controller's busy also covers its power-up init.
  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    grant_vld = 1'b0;
    pick_b    = 1'b0;
    if (!psram_busy) begin
      if (a_req && b_req && defer_cnt == DEFER_MAX) begin
        grant_vld = 1'b1;
        pick_b    = 1'b1;
      end else if (a_req) begin
        grant_vld = 1'b1;
      end else if (b_req) begin
        grant_vld = 1'b1;
        pick_b    = 1'b1;
      end
    end
  end

  assign sel_we   = pick_b ? b_we   : a_we;
  assign sel_addr = pick_b ? b_addr : a_addr;
  assign sel_din  = pick_b ? b_din  : a_din;
  assign rd_byte  = psram_addr[0] ? psram_dout[15:8] : psram_dout[7:0];

  // The latched address/data live directly in psram_addr/psram_din so they are stable
  // for the whole transaction regardless of what the requester does after the grant.
  // NOTE: sequential state uses non-blocking assignments only; the pulse/ack defaults at the
  // top are overridden later in the same block, which is what makes them one-cycle pulses.
  always_ff @(posedge clk_72m or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      state       <= ST_IDLE;
      defer_cnt   <= '0;
      cur_we      <= 1'b0;
      psram_read  <= 1'b0;
      psram_write <= 1'b0;
      psram_addr  <= '0;
      psram_din   <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_dout      <= '0;
      b_dout      <= '0;
      grant_b     <= 1'b0;
    end else begin
      psram_read  <= 1'b0;
      psram_write <= 1'b0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!b_req) begin
            defer_cnt <= '0;
          end
          if (grant_vld) begin
            cur_we      <= sel_we;
            psram_addr  <= sel_addr;
            psram_din   <= {sel_din, sel_din};
            psram_write <= sel_we;
            psram_read  <= !sel_we;
            grant_b     <= pick_b;
            if (pick_b) begin
              defer_cnt <= '0;
            end else if (b_req && defer_cnt != DEFER_MAX) begin
              defer_cnt <= defer_cnt + 8'd1;
            end
            state <= ST_ISSUE;
          end
        end

        // The command pulse is high during ISSUE; SETTLE gives the controller a cycle to raise busy.
        ST_ISSUE:  state <= ST_SETTLE;
        ST_SETTLE: state <= ST_WAIT_DONE;

        ST_WAIT_DONE: begin
          if (!psram_busy) begin
            if (!cur_we) begin
              if (grant_b) b_dout <= rd_byte;
              else         a_dout <= rd_byte;
            end
            if (grant_b) b_ack <= 1'b1;
            else         a_ack <= 1'b1;
            state <= ST_ACK;
          end
        end

        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter: behavioural PSRAM controller model plus an
// in-order transaction scoreboard checked on every command pulse and every ack.
module tb_psram_arbiter;

  localparam int ADDR_W = 22;

  logic              clk_72m = 1'b0;
  logic              bus_reset_n = 1'b0;
  logic              a_req = 1'b0, a_we = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic [7:0]        a_din = '0;
  logic              a_ack;
  logic [7:0]        a_dout;
  logic              b_req = 1'b0, b_we = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [7:0]        b_din = '0;
  logic              b_ack;
  logic [7:0]        b_dout;
  logic              psram_read, psram_write;
  logic [ADDR_W-1:0] psram_addr;
  logic [15:0]       psram_din;
  logic [15:0]       psram_dout = '0;
  logic              psram_busy;
  logic              grant_b;

  logic init_busy = 1'b1;
  logic op_busy   = 1'b0;
  assign psram_busy = init_busy | op_busy;

  always #7 clk_72m = ~clk_72m;

  psram_arbiter #(.B_MAX_DEFER(8), .ADDR_W(ADDR_W)) dut (
    .clk_72m(clk_72m), .bus_reset_n(bus_reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_ack(a_ack), .a_dout(a_dout),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_ack(b_ack), .b_dout(b_dout),
    .psram_read(psram_read), .psram_write(psram_write), .psram_addr(psram_addr),
    .psram_din(psram_din), .psram_dout(psram_dout), .psram_busy(psram_busy),
    .grant_b(grant_b)
  );

  typedef struct {
    logic              port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
    logic [7:0]        exp;
  } txn_t;

  typedef struct {
    logic              port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
    int                busy_t;
    logic [7:0]        exp;
  } vec_t;

  txn_t        sbq[$];
  logic [15:0] mem[int];
  int          n_vec = 0, n_err = 0;
  int          n_pulses = 0, n_acks = 0;
  int          busy_t = 0, busy_left = 0;
  logic        prev_pulse = 1'b0;
  logic [7:0]  exp_a_dout = '0, exp_b_dout = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  // Advances one cycle to the falling edge, then plays controller model and scoreboard.
  task automatic tick();
    txn_t e;
    logic pulse;
    int   key;
    @(negedge clk_72m);
    if (!bus_reset_n) begin
      op_busy    = 1'b0;
      busy_left  = 0;
      prev_pulse = 1'b0;
      return;
    end
    pulse = psram_read | psram_write;
    if (pulse) begin
      n_pulses++;
      check("pulse_exclusive", 32'(psram_read & psram_write), 32'd0);
      check("pulse_spacing", 32'(prev_pulse), 32'd0);
      if (sbq.size() == 0) fail_now("pulse_without_request");
      else begin
        e = sbq[0];
        check("pulse_owner", 32'(grant_b), 32'(e.port));
        check("pulse_we", 32'(psram_write), 32'(e.we));
        check("pulse_addr", 32'(psram_addr), 32'(e.addr));
        if (e.we) check("pulse_din", 32'(psram_din), 32'({e.din, e.din}));
      end
      key = int'(psram_addr[ADDR_W-1:1]);
      if (psram_write) mem[key] = psram_din;
      psram_dout = mem.exists(key) ? mem[key] : 16'hBEEF;
      op_busy    = 1'b1;
      busy_left  = busy_t + 2;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) op_busy = 1'b0;
    end
    prev_pulse = pulse;

    if (a_ack | b_ack) begin
      n_acks++;
      check("ack_exclusive", 32'(a_ack & b_ack), 32'd0);
      if (sbq.size() == 0) fail_now("ack_without_request");
      else begin
        e = sbq.pop_front();
        check("ack_port", 32'(b_ack), 32'(e.port));
        if (!e.we) begin
          if (e.port) exp_b_dout = e.exp;
          else        exp_a_dout = e.exp;
        end
        check("a_dout", 32'(a_dout), 32'(exp_a_dout));
        check("b_dout", 32'(b_dout), 32'(exp_b_dout));
      end
    end
  endtask

  task automatic wait_ack(input logic port, input int exp_lat, input bit scramble, input string name);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      tick();
      n++;
      if (scramble && n == 1) begin
        if (port) begin b_addr = ~b_addr; b_din = ~b_din; end
        else      begin a_addr = ~a_addr; a_din = ~a_din; end
      end
      if (port ? b_ack : a_ack) got = 1'b1;
    end
    check({name, "_ack_seen"}, 32'(got), 32'd1);
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    if (port) b_req = 1'b0;
    else      a_req = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    busy_t = v.busy_t;
    sbq.push_back('{v.port, v.we, v.addr, v.din, v.exp});
    if (v.port) begin b_we = v.we; b_addr = v.addr; b_din = v.din; b_req = 1'b1; end
    else        begin a_we = v.we; a_addr = v.addr; a_din = v.din; a_req = 1'b1; end
    wait_ack(v.port, 4 + v.busy_t, 1'b1, name);
    tick();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rd"},    32'(psram_read), 32'd0);
    check({name, "_wr"},    32'(psram_write), 32'd0);
    check({name, "_acks"},  32'({a_ack, b_ack}), 32'd0);
    check({name, "_douts"}, 32'({a_dout, b_dout}), 32'd0);
    check({name, "_addr"},  32'(psram_addr), 32'd0);
    check({name, "_din"},   32'(psram_din), 32'd0);
    check({name, "_grant"}, 32'(grant_b), 32'd0);
  endtask

  vec_t vt[10];

  initial begin
    int p0, k0, a_cnt, b_cnt, a_at_b;
    logic gb_prev;

    vt[0] = '{1'b0, 1'b1, 22'h012345, 8'h5A, 2, 8'h00};
    vt[1] = '{1'b0, 1'b0, 22'h012345, 8'h00, 0, 8'h5A};
    vt[2] = '{1'b0, 1'b0, 22'h000100, 8'h00, 3, 8'hEF};
    vt[3] = '{1'b1, 1'b0, 22'h000101, 8'h00, 1, 8'hBE};
    vt[4] = '{1'b1, 1'b1, 22'h000100, 8'h3C, 0, 8'h00};
    vt[5] = '{1'b1, 1'b0, 22'h000100, 8'h00, 5, 8'h3C};
    vt[6] = '{1'b0, 1'b0, 22'h000101, 8'h00, 0, 8'h3C};
    vt[7] = '{1'b0, 1'b1, 22'h3FFFFF, 8'hFF, 0, 8'h00};
    vt[8] = '{1'b1, 1'b0, 22'h3FFFFF, 8'h00, 2, 8'hFF};
    vt[9] = '{1'b1, 1'b0, 22'h000000, 8'h00, 0, 8'hEF};

    // Reset state
    tick();
    tick();
    check_reset_outputs("reset");
    check("reset_defer", 32'(dut.defer_cnt), 32'd0);
    bus_reset_n = 1'b1;
    tick();

    // Init hold-off: controller busy for 1000 cycles with A waiting
    busy_t = 1;
    sbq.push_back('{1'b0, 1'b0, 22'h000200, 8'h00, 8'hEF});
    a_we = 1'b0; a_addr = 22'h000200; a_req = 1'b1;
    p0 = n_pulses; k0 = n_acks;
    for (int i = 0; i < 1000; i++) tick();
    check("holdoff_pulses", 32'(n_pulses - p0), 32'd0);
    check("holdoff_acks", 32'(n_acks - k0), 32'd0);
    init_busy = 1'b0;
    tick();
    check("holdoff_first_pulse", 32'(n_pulses - p0), 32'd1);
    wait_ack(1'b0, 3 + busy_t, 1'b0, "holdoff");
    tick();

    // Table-driven single transactions
    for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Simultaneous requests: A first, then B
    busy_t = 1;
    sbq.push_back('{1'b0, 1'b1, 22'h000010, 8'h11, 8'h00});
    sbq.push_back('{1'b1, 1'b0, 22'h000011, 8'h00, 8'h11});
    a_we = 1'b1; a_addr = 22'h000010; a_din = 8'h11;
    b_we = 1'b0; b_addr = 22'h000011;
    a_req = 1'b1; b_req = 1'b1;
    wait_ack(1'b0, 4 + busy_t, 1'b0, "simul_a");
    wait_ack(1'b1, 5 + busy_t, 1'b0, "simul_b");
    tick();

    // Fairness: A streams back-to-back while B is held
    busy_t = 1;
    for (int i = 0; i < 8; i++) sbq.push_back('{1'b0, 1'b1, 22'h000020, 8'h77, 8'h00});
    sbq.push_back('{1'b1, 1'b0, 22'h000400, 8'h00, 8'hEF});
    for (int i = 0; i < 2; i++) sbq.push_back('{1'b0, 1'b1, 22'h000020, 8'h77, 8'h00});
    a_we = 1'b1; a_addr = 22'h000020; a_din = 8'h77;
    b_we = 1'b0; b_addr = 22'h000400;
    a_req = 1'b1; b_req = 1'b1;
    a_cnt = 0; b_cnt = 0; a_at_b = -1; gb_prev = grant_b;
    for (int n = 0; n < 3000 && (a_cnt + b_cnt) < 11; n++) begin
      tick();
      if (a_ack) a_cnt++;
      if (b_ack) begin b_cnt++; a_at_b = a_cnt; b_req = 1'b0; end
      if (grant_b && !gb_prev) check("fair_defer_after_b", 32'(dut.defer_cnt), 32'd0);
      gb_prev = grant_b;
    end
    a_req = 1'b0;
    check("fair_a_before_b", 32'(a_at_b), 32'd8);
    check("fair_b_acks", 32'(b_cnt), 32'd1);
    check("fair_a_acks", 32'(a_cnt), 32'd10);
    tick();
    tick();

    // Reset during WAIT_DONE of a B read
    busy_t = 30;
    sbq.push_back('{1'b1, 1'b0, 22'h000300, 8'h00, 8'h00});
    b_we = 1'b0; b_addr = 22'h000300; b_req = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    bus_reset_n = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    sbq.delete();
    exp_a_dout = '0; exp_b_dout = '0;
    b_req = 1'b0;
    tick(); tick(); tick();
    bus_reset_n = 1'b1;
    p0 = n_pulses; k0 = n_acks;
    for (int i = 0; i < 10; i++) tick();
    check("midop_no_ack", 32'(n_acks - k0), 32'd0);
    check("midop_no_pulse", 32'(n_pulses - p0), 32'd0);
    run_vec('{1'b0, 1'b0, 22'h012345, 8'h00, 2, 8'h5A}, "post_reset_a");

    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
Two-port arbiter and sequencer in front of PsramController (clk_72m domain). Port A serves the MSX slot/mapper FSM (latency-critical, high priority). Port B serves a background requester such as a ROM loader or memory tester. The block converts level-held byte requests into the controller's one-cycle read/write pulses, tracks busy, and returns byte data with a one-cycle ack. A bounded-deferral rule guarantees B progress under sustained A traffic.

Parameters:
B_MAX_DEFER, 8, number of consecutive A grants allowed while b_req is pending before B is forced (1..255)
ADDR_W, 22, PSRAM byte address width

Ports:
clk_72m  in  1  system clock, 72 MHz
bus_reset_n  in  1  reset, asynchronous, active-low
a_req  in  1  port A request, level, held until a_ack
a_we  in  1  port A: 1=write, 0=read
a_addr  in  ADDR_W  port A byte address
a_din  in  8  port A write byte
a_ack  out  1  port A one-cycle completion pulse
a_dout  out  8  port A read byte, valid with a_ack, held until next A read ack
b_req, b_we, b_addr, b_din, b_ack, b_dout  same as port A, for port B
psram_read  out  1  one-cycle read pulse to controller
psram_write  out  1  one-cycle write pulse to controller
psram_addr  out  ADDR_W  registered address to controller
psram_din  out  16  write word, {din,din}
psram_dout  in  16  controller read word
psram_busy  in  1  controller busy
grant_b  out  1  1 while the current/last transaction belongs to B (status/LED)

Behaviour:
- Reset values (async, bus_reset_n=0): state=IDLE; psram_read=psram_write=0; a_ack=b_ack=0; a_dout=b_dout=0; psram_addr=0; psram_din=0; grant_b=0; defer_cnt=0. A reset mid-transaction abandons it with no ack.
- States: IDLE, ISSUE, SETTLE, WAIT_DONE, ACK.
- IDLE: arbitrate only when psram_busy=0 (covers controller 150 us init). Winner rule: if a_req and b_req and defer_cnt==B_MAX_DEFER -> B; else if a_req -> A; else if b_req -> B; else stay. On a grant, latch we, addr, din and owner; set grant_b=owner; go to ISSUE.
- defer_cnt: +1 when A is granted while b_req=1 (saturates at B_MAX_DEFER); cleared when B is granted or when b_req=0 in IDLE.
- ISSUE: psram_addr=latched addr; psram_din={din,din}; pulse psram_write (we=1) or psram_read (we=0) for exactly 1 cycle; go to SETTLE.
- SETTLE: pulses low; 1 cycle only, so the controller can raise busy; go to WAIT_DONE.
- WAIT_DONE: remain while psram_busy=1; on psram_busy=0, for a read, capture owner's dout = addr[0] ? psram_dout[15:8] : psram_dout[7:0]; go to ACK.
- ACK: owner's ack=1 for exactly 1 cycle; return to IDLE. A requester still asserting req in the following IDLE cycle is treated as a new request, so requesters must drop req on ack.
- Latency: request sampled in IDLE cycle N -> pulse at N+1 -> ack at N+4+T, where T = cycles busy stays high after SETTLE. Minimum ack-to-next-pulse gap is 2 cycles.
- Only one of psram_read/psram_write is ever high, never on consecutive cycles. At most one ack per cycle.
- Inputs other than req are don't-care outside the IDLE grant cycle. Changing addr/din after the grant does not affect the transaction.
- The non-owner's dout is never modified. Write transactions leave both dout registers unchanged.

Test Plan:
- Basic round-trip: after init (busy low), A writes 0x5A to 0x012345, then A reads 0x012345 -> one psram_write pulse with psram_din=0x5A5A and psram_addr=0x012345; the read ack returns a_dout=0x5A from the upper byte.
- Simultaneous requests: a_req and b_req rise in the same cycle with defer_cnt=0 -> A is served first (grant_b=0), then B (grant_b=1), giving two acks in order A then B with no overlapping pulses.
- Fairness: A re-requests back-to-back while b_req is held -> exactly 8 A acks, then 1 B ack, then A resumes; defer_cnt reads 0 after the B grant.
- Init hold-off: psram_busy held high for 1000 cycles with a_req=1 -> no pulses and no ack until busy falls; the first pulse occurs 1 cycle after the grant.
- Reset mid-op: bus_reset_n asserted during WAIT_DONE of a B read -> all outputs return to their reset values immediately; no b_ack; after release, a new A read completes normally.
- Byte select: the model returns psram_dout=0xBEEF; read at even address 0x000100 -> dout=0xEF; read at odd address 0x000101 -> dout=0xBE, each delivered on the correct port only.
